// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the div_ctrl clock-divider controller.
package div_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrlState;

    localparam int MIN_DIV   = 2;
    localparam int TICKCNT_W = 16;

endpackage

// File: rtl/div_ctrl_core.sv
// Period counter for div_ctrl: owns cnt, the wrap compare and the registered
// outCLK / tick outputs. The parent supplies the active and next divisor.
module div_ctrl_core #(
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loadStart,
    input  logic             runEn,
    input  logic             stopNow,
    input  logic [WIDTH-1:0] div,
    input  logic [WIDTH-1:0] divNext,
    output logic             wrap,
    output logic             outClk,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cntNext;

    always_comb begin
        wrap    = runEn && (cnt == (div - WIDTH'(1)));
        cntNext = cnt;
        if (loadStart) begin
            cntNext = '0;
        end else if (runEn) begin
            cntNext = wrap ? '0 : cnt + WIDTH'(1);
        end
    end

    // outCLK is high for the first floor(N/2) counts of each period, so the
    // rising edge always lines up with cnt returning to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            outClk <= 1'b0;
            tick   <= 1'b0;
        end else begin
            cnt <= cntNext;
            if (loadStart || (runEn && !stopNow)) begin
                outClk <= (cntNext < (divNext >> 1));
            end else begin
                outClk <= 1'b0;
            end
            tick <= runEn && wrap && !stopNow;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Slow-clock controller: start / graceful stop FSM plus a ready/valid divisor
// reload applied only at period boundaries. Optional macro: DIV_CTRL_TICKCNT_EN.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int          WIDTH       = 28,
    parameter int unsigned DEFAULT_DIV = 100_000_000
) (
    input  logic                 inCLK,
    input  logic                 inRST,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 cfgValid,
    input  logic [WIDTH-1:0]     cfgDiv,
    output logic                 cfgReady,
    output logic                 outCLK,
    output logic                 tickOut,
`ifdef DIV_CTRL_TICKCNT_EN
    output logic                 running,
    output logic [TICKCNT_W-1:0] tickCnt
`else
    output logic                 running
`endif
);

    function automatic logic [WIDTH-1:0] clampDiv(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : d;
    endfunction

    ctrlState         state;
    ctrlState         stateNext;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] divNext;
    logic [WIDTH-1:0] shadowDiv;
    logic             shadowVld;
    logic             shadowVldNext;
    logic             stopPend;
    logic             stopPendNext;
    logic             accept;
    logic             runEn;
    logic             loadStart;
    logic             wrap;
    logic             stopNow;

    assign cfgReady  = !shadowVld;
    assign accept    = cfgValid && cfgReady;
    assign runEn     = (state == RUN);
    assign loadStart = (state == IDLE) && start;
    // A stop seen on the wrap cycle itself ends the run at that wrap.
    assign stopNow   = runEn && wrap && (stopPend || stop);
    assign running   = runEn;

    always_comb begin
        stateNext     = state;
        divNext       = div;
        shadowVldNext = shadowVld;
        stopPendNext  = stopPend;
        case (state)
            IDLE: begin
                stopPendNext = 1'b0;
                // A divisor accepted on the stopping wrap lands here.
                if (shadowVld) begin
                    divNext       = shadowDiv;
                    shadowVldNext = 1'b0;
                end else if (accept) begin
                    divNext = clampDiv(cfgDiv);
                end
                if (start) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    stopPendNext = 1'b1;
                end
                if (accept) begin
                    shadowVldNext = 1'b1;
                end
                if (wrap) begin
                    if (shadowVld) begin
                        divNext       = shadowDiv;
                        shadowVldNext = 1'b0;
                    end
                    if (stopPend || stop) begin
                        stateNext    = IDLE;
                        stopPendNext = 1'b0;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge inCLK) begin
        if (inRST) begin
            state     <= IDLE;
            div       <= WIDTH'(DEFAULT_DIV);
            shadowVld <= 1'b0;
            stopPend  <= 1'b0;
        end else begin
            state     <= stateNext;
            div       <= divNext;
            shadowVld <= shadowVldNext;
            stopPend  <= stopPendNext;
        end
    end

    always_ff @(posedge inCLK) begin
        if (accept && runEn) begin
            shadowDiv <= clampDiv(cfgDiv);
        end
    end

    div_ctrl_core #(
        .WIDTH(WIDTH)
    ) core (
        .clk      (inCLK),
        .rst      (inRST),
        .loadStart(loadStart),
        .runEn    (runEn),
        .stopNow  (stopNow),
        .div      (div),
        .divNext  (divNext),
        .wrap     (wrap),
        .outClk   (outCLK),
        .tick     (tickOut)
    );

`ifdef DIV_CTRL_TICKCNT_EN
    always_ff @(posedge inCLK) begin
        if (inRST || loadStart) begin
            tickCnt <= '0;
        end else if (tickOut) begin
            tickCnt <= tickCnt + TICKCNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl with DEFAULT_DIV overridden to 10.
module tb_div_ctrl;

    localparam int WIDTH = 28;

    logic             inCLK = 1'b0;
    logic             inRST = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             cfgValid = 1'b0;
    logic [WIDTH-1:0] cfgDiv = '0;
    logic             cfgReady;
    logic             outCLK;
    logic             tickOut;
    logic             running;
`ifdef DIV_CTRL_TICKCNT_EN
    logic [15:0]      tickCnt;
`endif

    int checks = 0;
    int failures = 0;

    div_ctrl #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(10)
    ) dut (
        .inCLK   (inCLK),
        .inRST   (inRST),
        .start   (start),
        .stop    (stop),
        .cfgValid(cfgValid),
        .cfgDiv  (cfgDiv),
        .cfgReady(cfgReady),
        .outCLK  (outCLK),
        .tickOut (tickOut),
`ifdef DIV_CTRL_TICKCNT_EN
        .running (running),
        .tickCnt (tickCnt)
`else
        .running (running)
`endif
    );

    always #5 inCLK = ~inCLK;

    task automatic startRun();
        @(negedge inCLK);
        start = 1'b1;
        @(posedge inCLK);
        #1 start = 1'b0;
    endtask

    task automatic setDiv(input logic [WIDTH-1:0] d);
        @(negedge inCLK);
        cfgValid = 1'b1;
        cfgDiv   = d;
        @(posedge inCLK);
        #1 cfgValid = 1'b0;
    endtask

    task automatic stopRun();
        @(negedge inCLK);
        stop = 1'b1;
        for (int n = 0; n < 64 && running === 1'b1; n++) @(negedge inCLK);
        stop = 1'b0;
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL stop_timeout: running=%b want 0", running);
        end
        checks++;
        if (outCLK !== 1'b0) begin
            failures++;
            $display("FAIL stop_outclk: outCLK=%b want 0", outCLK);
        end
    endtask

    task automatic test_reset();
        inRST = 1'b1;
        repeat (2) @(posedge inCLK);
        #1 inRST = 1'b0;
        @(negedge inCLK);
        checks++;
        if ({outCLK, tickOut, running, cfgReady} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_state: {clk,tick,run,rdy}=%b want 0001",
                     {outCLK, tickOut, running, cfgReady});
        end
`ifdef DIV_CTRL_TICKCNT_EN
        checks++;
        if (tickCnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_tickcnt: got %0d want 0", tickCnt);
        end
`endif
    endtask

    task automatic test_default_run();
        int cn;
        logic [2:0] exp;
        startRun();
        for (int i = 1; i <= 35; i++) begin
            @(negedge inCLK);
            cn  = (i - 1) % 10;
            exp = {cn < 5, (i >= 11) && (cn == 0), 1'b1};
            checks++;
            if ({outCLK, tickOut, running} !== exp) begin
                failures++;
                $display("FAIL default_run cyc%0d: {clk,tick,run}=%b want %b",
                         i, {outCLK, tickOut, running}, exp);
            end
        end
        stopRun();
    endtask

    task automatic test_clamp();
        int cn;
        logic [2:0] exp;
        setDiv(1);
        @(negedge inCLK);
        checks++;
        if (cfgReady !== 1'b1) begin
            failures++;
            $display("FAIL clamp_ready: cfgReady=%b want 1", cfgReady);
        end
        startRun();
        for (int i = 1; i <= 12; i++) begin
            @(negedge inCLK);
            cn  = (i - 1) % 2;
            exp = {cn < 1, (i >= 3) && (cn == 0), 1'b1};
            checks++;
            if ({outCLK, tickOut, running} !== exp) begin
                failures++;
                $display("FAIL clamp_run cyc%0d: {clk,tick,run}=%b want %b",
                         i, {outCLK, tickOut, running}, exp);
            end
        end
        stopRun();
    endtask

    task automatic test_reload();
        int cn;
        int half;
        logic [3:0] exp;
        setDiv(10);
        startRun();
        for (int i = 1; i <= 26; i++) begin
            @(negedge inCLK);
            if (i <= 10) begin
                cn   = i - 1;
                half = 5;
            end else begin
                cn   = (i - 11) % 4;
                half = 2;
            end
            exp = {cn < half, (i >= 11) && (cn == 0), 1'b1, !(i >= 5 && i <= 10)};
            checks++;
            if ({outCLK, tickOut, running, cfgReady} !== exp) begin
                failures++;
                $display("FAIL reload cyc%0d: {clk,tick,run,rdy}=%b want %b",
                         i, {outCLK, tickOut, running, cfgReady}, exp);
            end
            if (i == 4) begin
                cfgValid = 1'b1;
                cfgDiv   = 4;
            end
            if (i == 5) cfgValid = 1'b0;
        end
        stopRun();
    endtask

    task automatic test_stop();
        logic [2:0] exp;
        setDiv(8);
        startRun();
        for (int i = 1; i <= 12; i++) begin
            @(negedge inCLK);
            exp = (i <= 8) ? {(i - 1) < 4, 1'b0, 1'b1} : 3'b000;
            checks++;
            if ({outCLK, tickOut, running} !== exp) begin
                failures++;
                $display("FAIL stop cyc%0d: {clk,tick,run}=%b want %b",
                         i, {outCLK, tickOut, running}, exp);
            end
            if (i == 4) stop = 1'b1;
            if (i == 5) begin
                stop  = 1'b0;
                start = 1'b1;
            end
            if (i == 8) start = 1'b0;
        end
    endtask

    task automatic test_idle_stop();
        @(negedge inCLK);
        stop = 1'b1;
        @(posedge inCLK);
        #1 stop = 1'b0;
        @(negedge inCLK);
        checks++;
        if ({outCLK, running} !== 2'b00) begin
            failures++;
            $display("FAIL idle_stop: {clk,run}=%b want 00", {outCLK, running});
        end
        startRun();
        for (int i = 1; i <= 10; i++) begin
            @(negedge inCLK);
            checks++;
            if ({tickOut, running} !== {i == 9, 1'b1}) begin
                failures++;
                $display("FAIL idle_stop_run cyc%0d: {tick,run}=%b want %b",
                         i, {tickOut, running}, {i == 9, 1'b1});
            end
        end
        stopRun();
    endtask

    task automatic test_start_stop_reset();
        logic [2:0] exp;
        @(negedge inCLK);
        start = 1'b1;
        stop  = 1'b1;
        @(posedge inCLK);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge inCLK);
            if (i <= 7) begin
                checks++;
                if ({outCLK, running} !== {(i - 1) < 4, 1'b1}) begin
                    failures++;
                    $display("FAIL start_stop cyc%0d: {clk,run}=%b want %b",
                             i, {outCLK, running}, {(i - 1) < 4, 1'b1});
                end
            end else begin
                checks++;
                if ({outCLK, tickOut, running, cfgReady} !== 4'b0001) begin
                    failures++;
                    $display("FAIL mid_reset: {clk,tick,run,rdy}=%b want 0001",
                             {outCLK, tickOut, running, cfgReady});
                end
                inRST = 1'b0;
            end
            if (i == 7) inRST = 1'b1;
        end
        startRun();
        for (int i = 1; i <= 12; i++) begin
            @(negedge inCLK);
            exp = {((i - 1) % 10) < 5, i == 11, 1'b1};
            checks++;
            if ({outCLK, tickOut, running} !== exp) begin
                failures++;
                $display("FAIL reset_div cyc%0d: {clk,tick,run}=%b want %b",
                         i, {outCLK, tickOut, running}, exp);
            end
        end
        stopRun();
    endtask

`ifdef DIV_CTRL_TICKCNT_EN
    task automatic test_tickcnt();
        setDiv(2);
        startRun();
        for (int i = 1; i <= 131074; i++) begin
            @(negedge inCLK);
            if (i == 4 || i == 131073 || i == 131074) begin
                checks++;
                if (tickCnt !== 16'((i - 2) / 2)) begin
                    failures++;
                    $display("FAIL tickcnt cyc%0d: got %h want %h",
                             i, tickCnt, 16'((i - 2) / 2));
                end
            end
        end
        stopRun();
    endtask
`endif

    initial begin
        test_reset();
        test_default_run();
        test_clamp();
        test_reload();
        test_stop();
        test_idle_stop();
        test_start_stop_reset();
`ifdef DIV_CTRL_TICKCNT_EN
        test_tickcnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
